mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - CPU fetch/data port and asynchronous SRAM port bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int SRAM_AW = 20
);
  logic [31:0]        pc;
  logic               inst_req;
  logic [31:0]        instruction;
  logic [31:0]        mem_addr;
  logic [31:0]        mem_wdata;
  logic [4:0]         mem_ctrl_signal;
  logic [31:0]        mem_rdata;
  logic               mem_stall;
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]        sram_wdata;
  logic [31:0]        sram_rdata;
  logic [3:0]         sram_be_n;
  logic               sram_ce_n;
  logic               sram_oe_n;
  logic               sram_we_n;

  modport slave (
    input  pc, inst_req, mem_addr, mem_wdata, mem_ctrl_signal, sram_rdata,
    output instruction, mem_rdata, mem_stall,
    output sram_addr, sram_wdata, sram_be_n, sram_ce_n, sram_oe_n, sram_we_n
  );

  modport master (
    output pc, inst_req, mem_addr, mem_wdata, mem_ctrl_signal, sram_rdata,
    input  instruction, mem_rdata, mem_stall,
    input  sram_addr, sram_wdata, sram_be_n, sram_ce_n, sram_oe_n, sram_we_n
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates instruction fetch and data access onto one shared asynchronous SRAM
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 20
) (
  input  logic          clk_50M,
  input  logic          reset_btn,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q;
  logic               d_served_q, i_served_q;
  logic [SRAM_AW+1:0] addr_q;
  logic [31:0]        wdata_q;
  logic               wr_q, sx_q;
  logic [1:0]         sz_q;
  logic [31:0]        instruction_q, rdata_q;
  logic               d_pend, i_pend, last;
  logic [4:0]         shamt;
  logic [31:0]        sh, load_ext;

  assign d_pend = (bus.mem_ctrl_signal[4] | bus.mem_ctrl_signal[3]) & ~d_served_q;
  assign i_pend = bus.inst_req & ~i_served_q;
  assign last   = (cnt_q == 3'(WAIT_CYCLES));

  assign bus.mem_stall   = d_pend | i_pend;
  assign bus.instruction = instruction_q;
  assign bus.mem_rdata   = rdata_q;
  assign bus.sram_addr   = addr_q[SRAM_AW+1:2];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         if (d_pend) state_d = D_ACC;
                    else if (i_pend) state_d = I_ACC;
      D_ACC, I_ACC: if (last) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or posedge reset_btn) begin
    if (reset_btn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == IDLE || last) ? 3'd0 : cnt_q + 3'd1;
    end
  end

  // Load lane extraction: half ignores addr[0], word ignores addr[1:0]
  always_comb begin
    shamt = 5'd0;
    if (sz_q == 2'b00)      shamt = {addr_q[1:0], 3'b000};
    else if (sz_q == 2'b01) shamt = {addr_q[1], 4'b0000};
    sh = bus.sram_rdata >> shamt;
    unique case (sz_q)
      2'b00:   load_ext = {{24{sx_q & sh[7]}}, sh[7:0]};
      2'b01:   load_ext = {{16{sx_q & sh[15]}}, sh[15:0]};
      default: load_ext = sh;
    endcase
  end

  always_ff @(posedge clk_50M or posedge reset_btn) begin
    if (reset_btn) begin
      d_served_q    <= 1'b0;
      i_served_q    <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wr_q          <= 1'b0;
      sx_q          <= 1'b0;
      sz_q          <= 2'b00;
      instruction_q <= '0;
      rdata_q       <= '0;
    end else begin
      if (!bus.mem_stall) begin
        d_served_q <= 1'b0;
        i_served_q <= 1'b0;
      end
      if (state_q == IDLE) begin
        if (d_pend) begin
          addr_q  <= bus.mem_addr[SRAM_AW+1:0];
          wdata_q <= bus.mem_wdata;
          wr_q    <= bus.mem_ctrl_signal[4];
          sx_q    <= bus.mem_ctrl_signal[2];
          sz_q    <= bus.mem_ctrl_signal[1:0];
        end else if (i_pend) begin
          addr_q  <= bus.pc[SRAM_AW+1:0];
          wr_q    <= 1'b0;
          sx_q    <= 1'b0;
          sz_q    <= 2'b10;
        end
      end
      if (state_q == D_ACC && last) begin
        d_served_q <= 1'b1;
        if (!wr_q) rdata_q <= load_ext;
      end
      if (state_q == I_ACC && last) begin
        i_served_q    <= 1'b1;
        instruction_q <= bus.sram_rdata;
      end
    end
  end

  // Strobes decode straight from state so reset releases the SRAM immediately
  always_comb begin
    bus.sram_ce_n  = 1'b1;
    bus.sram_oe_n  = 1'b1;
    bus.sram_we_n  = 1'b1;
    bus.sram_be_n  = 4'b1111;
    bus.sram_wdata = wdata_q;
    unique case (sz_q)
      2'b00:   bus.sram_wdata = {4{wdata_q[7:0]}};
      2'b01:   bus.sram_wdata = {2{wdata_q[15:0]}};
      default: bus.sram_wdata = wdata_q;
    endcase
    unique case (state_q)
      I_ACC: begin
        bus.sram_ce_n = 1'b0;
        bus.sram_oe_n = 1'b0;
        bus.sram_be_n = 4'b0000;
      end
      D_ACC: begin
        bus.sram_ce_n = 1'b0;
        unique case (sz_q)
          2'b00:   bus.sram_be_n = ~(4'b0001 << addr_q[1:0]);
          2'b01:   bus.sram_be_n = addr_q[1] ? 4'b0011 : 4'b1100;
          default: bus.sram_be_n = 4'b0000;
        endcase
        if (wr_q) bus.sram_we_n = last;
        else      bus.sram_oe_n = 1'b0;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int W  = 1;
  localparam int AW = 20;
  localparam logic [31:0] K = 32'h9E3779B1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] salt = 32'h0;
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_rdata = 32'h0;
  logic [31:0] exp_instr = 32'h0;

  mem_arbiter_if #(.SRAM_AW(AW)) bus();

  mem_arbiter #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk_50M   (clk),
    .reset_btn (rst),
    .bus       (bus)
  );

  always #10 clk = ~clk;

  // SRAM contents: a pseudo-random word per address, reshuffled by salt
  assign bus.sram_rdata = (32'(bus.sram_addr) * K) ^ salt;

  function automatic logic [31:0] rd_of(input logic [31:0] byte_addr);
    return (32'(byte_addr[AW+1:2]) * K) ^ salt;
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] word, input logic [31:0] a,
                                             input bit sx, input logic [1:0] sz);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (word >> (8 * (a % 4))) & 32'hFF;
      if (sx && v >= 32'h80) v = v - 32'h100;
    end else if (sz == 2'b01) begin
      v = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [3:0] be_model(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'b00) return 4'(15 - (1 << (a % 4)));
    if (sz == 2'b01) return ((a / 2) % 2 == 1) ? 4'b0011 : 4'b1100;
    return 4'b0000;
  endfunction

  function automatic logic [31:0] wdata_model(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'b00) return (d % 256) * 32'h01010101;
    if (sz == 2'b01) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input bit iq, input logic [4:0] ctrl, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] p, input bit scramble);
    bit dq, wr, done, first;
    int stall_n, ce_cnt, we_cnt, oe_cnt, acc_len;
    logic [3:0]    be_first, be_last;
    logic [AW-1:0] ad_first, ad_last;
    logic [31:0]   wd_first;
    dq = ctrl[4] | ctrl[3];
    wr = ctrl[4];
    acc_len = W + 1;
    stall_n = 0; ce_cnt = 0; we_cnt = 0; oe_cnt = 0; done = 0; first = 1;
    be_first = 4'hF; be_last = 4'hF; ad_first = '0; ad_last = '0; wd_first = '0;
    @(negedge clk);
    bus.pc = p; bus.inst_req = iq; bus.mem_addr = a; bus.mem_wdata = wd; bus.mem_ctrl_signal = ctrl;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!bus.mem_stall) begin
        done = 1;
        break;
      end
      stall_n++;
      if (!bus.sram_ce_n) begin
        ce_cnt++;
        if (!bus.sram_we_n) we_cnt++;
        if (!bus.sram_oe_n) oe_cnt++;
        if (first) begin
          be_first = bus.sram_be_n; ad_first = bus.sram_addr; wd_first = bus.sram_wdata; first = 0;
        end
        be_last = bus.sram_be_n; ad_last = bus.sram_addr;
        if (scramble) begin
          if (dq && ce_cnt <= acc_len) begin
            bus.mem_addr = $urandom; bus.mem_wdata = $urandom;
          end else begin
            bus.pc = $urandom;
          end
        end
      end
      @(negedge clk);
    end
    bus.inst_req = 1'b0;
    bus.mem_ctrl_signal = 5'b0;
    check("stall_released", 32'(done), 32'd1);
    check("stall_cycles", stall_n, (dq ? W + 2 : 0) + (iq ? W + 2 : 0));
    check("ce_cycles", ce_cnt, (dq ? acc_len : 0) + (iq ? acc_len : 0));
    check("we_cycles", we_cnt, (dq && wr) ? W : 0);
    check("oe_cycles", oe_cnt, ((dq && !wr) ? acc_len : 0) + (iq ? acc_len : 0));
    if (dq) begin
      check("data_be_n", 32'(be_first), 32'(be_model(a, ctrl[1:0])));
      check("data_addr", 32'(ad_first), 32'(a[AW+1:2]));
      if (wr) check("sram_wdata", wd_first, wdata_model(wd, ctrl[1:0]));
      else exp_rdata = load_model(rd_of(a), a, ctrl[2], ctrl[1:0]);
    end
    if (iq) begin
      check("fetch_be_n", 32'(be_last), 32'h0);
      check("fetch_addr", 32'(ad_last), 32'(p[AW+1:2]));
      exp_instr = rd_of(p);
    end
    check("mem_rdata", bus.mem_rdata, exp_rdata);
    check("instruction", bus.instruction, exp_instr);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_strobes"}, {29'h0, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}, 32'h7);
    check({tag, "_be_n"}, 32'(bus.sram_be_n), 32'hF);
    check({tag, "_sram_addr"}, 32'(bus.sram_addr), 32'h0);
    check({tag, "_sram_wdata"}, bus.sram_wdata, 32'h0);
    check({tag, "_mem_rdata"}, bus.mem_rdata, 32'h0);
    check({tag, "_instruction"}, bus.instruction, 32'h0);
  endtask

  initial begin
    logic [4:0] ctrl;
    logic [31:0] a;
    int kind;
    bit wr, rd;
    bus.pc = 32'h0; bus.inst_req = 1'b0; bus.mem_addr = 32'h0;
    bus.mem_wdata = 32'h0; bus.mem_ctrl_signal = 5'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset_stall", 32'(bus.mem_stall), 32'h0);
    rst = 1'b0;

    salt = 32'h3C011234 ^ (32'h4 * K);
    run_txn(1'b1, 5'b0, 32'h0, 32'h0, 32'h00000010, 1'b0);
    check("fetch_0x10", bus.instruction, 32'h3C011234);

    salt = 32'h80FF7F01 ^ (32'h40 * K);
    run_txn(1'b0, 5'b01100, 32'h00000103, 32'h0, 32'h0, 1'b0);
    check("lb_signed", bus.mem_rdata, 32'hFFFFFF80);
    run_txn(1'b0, 5'b01000, 32'h00000103, 32'h0, 32'h0, 1'b0);
    check("lb_unsigned", bus.mem_rdata, 32'h00000080);

    run_txn(1'b0, 5'b10001, 32'h00000202, 32'h0000ABCD, 32'h0, 1'b0);
    run_txn(1'b1, 5'b01010, 32'h00001234, 32'h0, 32'h00000400, 1'b0);
    run_txn(1'b1, 5'b0, 32'h0, 32'h0, 32'h00000804, 1'b1);

    // Reset in the middle of a store, then re-issue it
    @(negedge clk);
    bus.mem_addr = 32'h00000202; bus.mem_wdata = 32'h0000ABCD; bus.mem_ctrl_signal = 5'b10001;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid_store_ce", 32'(bus.sram_ce_n), 32'h0);
    rst = 1'b1;
    bus.mem_ctrl_signal = 5'b0;
    #1;
    check_idle_outputs("abort");
    exp_rdata = 32'h0;
    exp_instr = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    run_txn(1'b0, 5'b10001, 32'h00000202, 32'h0000ABCD, 32'h0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      salt = $urandom;
      kind = $urandom_range(0, 2);
      wr = 1'($urandom);
      rd = !wr || 1'($urandom);
      a  = $urandom;
      ctrl = {wr, rd, 1'($urandom), 2'($urandom_range(0, 2))};
      if (kind == 1) ctrl = {2'b00, ctrl[2:0]};
      run_txn(kind != 0, ctrl, a, $urandom, $urandom, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
